// File: rtl/fetch_decode_unit.sv
// Instruction-side controller for the 4-bit processor: fetches from the
// combinational ROM, decodes the 8-bit word and issues one-cycle strobes.
module fetch_decode_unit #(
  parameter logic [3:0] RESET_PC      = 4'd1,
  parameter bit         HALT_ON_STORE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Run,
  input  logic [7:0] Instruction,
  output logic [3:0] ProgramCounter,
  output logic       RegWrite,
  output logic [1:0] WriteAddr,
  output logic [1:0] ReadAddrA,
  output logic [1:0] ReadAddrB,
  output logic [3:0] Immediate,
  output logic [1:0] WriteSel,
  output logic [1:0] AluOp,
  output logic       StoreEn,
  output logic       Halted,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_DECODE  = 2'b01,
    S_EXECUTE = 2'b10,
    S_HALT    = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_MOVE  = 2'b10,
    OP_ALU   = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    WSEL_IMM  = 2'b00,
    WSEL_MOVE = 2'b01,
    WSEL_ALU  = 2'b10
  } wsel_e;

  typedef struct packed {
    logic [1:0] write_addr;
    logic [1:0] read_addr_a;
    logic [1:0] read_addr_b;
    logic [3:0] immediate;
    wsel_e      write_sel;
    logic [1:0] alu_op;
  } fields_t;

  state_e     state;
  state_e     state_next;
  logic [3:0] pc;
  logic [7:0] ir;
  opcode_e    opcode;
  fields_t    fields_dec;
  fields_t    fields_q;

  assign opcode = opcode_e'(ir[7:6]);

  // Field extraction from the latched instruction word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fields_dec             = '0;
    fields_dec.write_addr  = ir[5:4];
    fields_dec.read_addr_a = ir[5:4];
    fields_dec.read_addr_b = ir[3:2];
    fields_dec.immediate   = ir[3:0];
    unique case (opcode)
      OP_LOAD:  fields_dec.write_sel = WSEL_IMM;
      OP_STORE: fields_dec.write_sel = WSEL_IMM;
      OP_MOVE:  fields_dec.write_sel = WSEL_MOVE;
      OP_ALU: begin
        fields_dec.write_sel = WSEL_ALU;
        fields_dec.alu_op    = ir[1:0];
      end
      default:  fields_dec.write_sel = WSEL_IMM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; Run only matters while waiting in FETCH.
  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH:   state_next = Run ? S_DECODE : S_FETCH;
      S_DECODE:  state_next = S_EXECUTE;
      S_EXECUTE: state_next = (HALT_ON_STORE && opcode == OP_STORE) ? S_HALT : S_FETCH;
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_FETCH;
    endcase
  end

  // Datapath registers: PC, instruction register and the held decode fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      ir       <= 8'h00;
      fields_q <= '0;
    end else begin
      if (state == S_FETCH && Run) begin
        ir <= Instruction;
      end
      if (state == S_DECODE) begin
        fields_q <= fields_dec;
      end
      if (state == S_EXECUTE) begin
        pc <= pc + 4'd1;
      end
    end
  end

  // Strobes are decoded from state so they can only ever fire in EXECUTE.
  always_comb begin
    RegWrite = 1'b0;
    StoreEn  = 1'b0;
    Halted   = 1'b0;
    unique case (state)
      S_EXECUTE: begin
        RegWrite = (opcode != OP_STORE);
        StoreEn  = (opcode == OP_STORE);
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

  assign ProgramCounter = pc;
  assign State          = state;
  assign WriteAddr      = fields_q.write_addr;
  assign ReadAddrA      = fields_q.read_addr_a;
  assign ReadAddrB      = fields_q.read_addr_b;
  assign Immediate      = fields_q.immediate;
  assign WriteSel       = fields_q.write_sel;
  assign AluOp          = fields_q.alu_op;

endmodule
